// File: rtl/mem_req_if.sv
// mem_req_if: request/response and memory-port bundle for mem_req_ctrl.
// slave  = the controller's view; master = EX + data memory environment.
interface mem_req_if #(
    parameter int SB_DEPTH = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
);
    localparam int CW = $clog2(SB_DEPTH + 1);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] sb_count;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata,
               mem_read, mem_write, sb_count
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wdata,
               mem_read, mem_write, sb_count
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage request controller in front of a single-ported
// data memory. Loads go to memory at once; stores park in a circular FIFO
// store buffer and drain only in cycles with no accepted request.
// Optional feature macro: SB_FWD_EN -- loads hitting a buffered store take
// the youngest matching entry's data. Without it, a load is held off until
// the buffer has fully drained and always reads memory.
module mem_req_ctrl #(
    parameter int SB_DEPTH = 4,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input logic      clk,
    input logic      rst_n,
    mem_req_if.slave bus
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(SB_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(SB_DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    sb_entry_t     sb_q [SB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          accept, push, pop, ld;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef SB_FWD_EN
    assign bus.req_ready = (count != FULL);
`else
    // A load must see memory fully up to date, so it waits for an empty buffer.
    assign bus.req_ready = (count != FULL) &&
                           !(bus.req_valid && !bus.req_we && count != '0);
`endif

    // The accepted request owns the memory port; drain only uses idle cycles.
    assign accept = rst_n && bus.req_valid && bus.req_ready;
    assign push   = accept && bus.req_we;
    assign ld     = accept && !bus.req_we;
    assign pop    = !accept && (count != '0);

`ifdef SB_FWD_EN
    localparam int PW1 = PW + 1;
    logic [SB_DEPTH-1:0]         age_hit;
    logic [SB_DEPTH-1:0][PW-1:0] age_idx;

    // Map age slot i (0 = oldest) to its physical index, modulo SB_DEPTH.
    for (genvar i = 0; i < SB_DEPTH; i++) begin : g_age
        logic [PW:0] sum;
        assign sum        = {1'b0, head} + PW1'(i);
        assign age_idx[i] = (sum >= PW1'(SB_DEPTH)) ? PW'(sum - PW1'(SB_DEPTH))
                                                    : sum[PW-1:0];
        assign age_hit[i] = (CW'(i) < count) &&
                            (sb_q[age_idx[i]].addr == bus.req_addr);
    end

    // Scan oldest to youngest so the last (youngest) match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (age_hit[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_q[age_idx[i]].data;
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Memory port: load read, else head drain, else quiet zeros.
    always_comb begin
        bus.mem_read  = ld && !fwd_hit;
        bus.mem_write = pop;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (ld) begin
            bus.mem_addr = bus.req_addr;
        end else if (pop) begin
            bus.mem_addr  = sb_q[head].addr;
            bus.mem_wdata = sb_q[head].data;
        end
    end

    // Entry payload; stale contents are harmless since count gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_q[tail].addr <= bus.req_addr;
            sb_q[tail].data <= bus.req_wdata;
        end
    end

    // FIFO pointers and occupancy; push and pop are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            if (push)     count <= count + 1'b1;
            else if (pop) count <= count - 1'b1;
        end
    end

    // One-cycle load response; data held between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= ld;
            if (ld) rsp_rdata_q <= fwd_hit ? fwd_data : bus.mem_rdata;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.sb_count  = count;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed stimulus with a scoreboard. Stimulus pushes
// expected load data and expected memory writes into queues; a negedge
// monitor pops and compares whenever the DUT responds or writes memory.
module tb_mem_req_ctrl;
    localparam int SB_DEPTH = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef SB_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_if #(.SB_DEPTH(SB_DEPTH), .AW(AW), .DW(DW)) bus();

    mem_req_ctrl #(.SB_DEPTH(SB_DEPTH), .AW(AW), .DW(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory model: combinational read, write at the edge.
    logic [DW-1:0] mem [0:255];
    always_comb bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rsp[$];
    int            checks = 0;
    int            errors = 0;
    wr_t           mon_w;
    logic [DW-1:0] mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: match responses and memory writes against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
                else begin
                    mon_e = exp_rsp.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, mon_e);
                end
            end
            if (bus.mem_write) begin
                chk("rd_wr_excl", bus.mem_read, 0);
                if (exp_wr.size() == 0) chk("wr_unexpected", bus.mem_write, 0);
                else begin
                    mon_w = exp_wr.pop_front();
                    chk("wr_addr", bus.mem_addr, mon_w.a);
                    chk("wr_data", bus.mem_wdata, mon_w.d);
                end
            end
        end
    end

    // Present one request and wait (bounded) for acceptance. For loads, d is
    // the expected read data; exp_mrd < 0 skips the mem_read check.
    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int exp_mrd);
        bit  ok = 1'b0;
        wr_t w;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = we ? d : '0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_ready_timeout", bus.req_ready, 1);
        else begin
            if (exp_mrd >= 0) begin
                chk("mem_read", bus.mem_read, exp_mrd);
                if (exp_mrd == 1) chk("mem_addr_rd", bus.mem_addr, a);
            end
            @(posedge clk); #1;
            if (we) begin
                w.a = a;
                w.d = d;
                exp_wr.push_back(w);
            end else exp_rsp.push_back(d);
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (bus.sb_count == 0) break;
        end
        chk("drain_done", bus.sb_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wr_t w;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // 1: reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sb_count", bus.sb_count, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;

        // 2: single store drains next idle cycle, then a load reads it back
        do_req(1'b1, 32'h8, 32'h9, 0);
        @(negedge clk);
        chk("t2_count_1", bus.sb_count, 1);
        chk("t2_mem_write", bus.mem_write, 1);
        @(negedge clk);
        chk("t2_count_0", bus.sb_count, 0);
        chk("t2_idle_write", bus.mem_write, 0);
        @(posedge clk); #1;
        do_req(1'b0, 32'h8, 32'h9, 1);
        @(negedge clk);
        chk("t2_rsp_pulse", bus.rsp_valid, 1);
        @(negedge clk);
        chk("t2_rsp_drop", bus.rsp_valid, 0);
        @(posedge clk); #1;

        // 3: fill the buffer, fifth store blocked until one entry drains
        for (int i = 0; i < 4; i++) do_req(1'b1, 32'h10 + i, 32'h100 + i, 0);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h14;
        bus.req_wdata = 32'h104;
        @(negedge clk);
        chk("t3_full_count", bus.sb_count, 4);
        chk("t3_full_ready", bus.req_ready, 0);
        chk("t3_full_drain", bus.mem_write, 1);
        @(negedge clk);
        chk("t3_count_3", bus.sb_count, 3);
        chk("t3_ready_back", bus.req_ready, 1);
        @(posedge clk); #1;
        w.a = 32'h14;
        w.d = 32'h104;
        exp_wr.push_back(w);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        @(negedge clk);
        chk("t3_count_refill", bus.sb_count, 4);
        wait_drain();
        @(posedge clk); #1;

        // 4: two stores to one address then a load; youngest data wins
        do_req(1'b1, 32'h20, 32'hA, 0);
        do_req(1'b1, 32'h20, 32'hB, 0);
        do_req(1'b0, 32'h20, 32'hB, (FWD != 0) ? 0 : 1);
        wait_drain();
        @(posedge clk); #1;

        // 5: move head to index 3, then fill across the wrap and forward
        for (int i = 0; i < 3; i++) do_req(1'b1, 32'h30 + i, 32'h300 + i, 0);
        wait_drain();
        @(posedge clk); #1;
        do_req(1'b1, 32'h41, 32'h401, 0);
        do_req(1'b1, 32'h42, 32'h402, 0);
        do_req(1'b1, 32'h41, 32'h4A1, 0);
        do_req(1'b0, 32'h41, 32'h4A1, (FWD != 0) ? 0 : 1);
        do_req(1'b0, 32'h42, 32'h402, (FWD != 0) ? 0 : 1);
        wait_drain();
        @(posedge clk); #1;

        // 6: reset with a loaded buffer (and a response pending if forwarding)
        for (int i = 0; i < 3; i++) do_req(1'b1, 32'h50 + i, 32'h500 + i, 0);
`ifdef SB_FWD_EN
        do_req(1'b0, 32'h51, 32'h501, 0);
        chk("t6_rsp_pending", bus.rsp_valid, 1);
`endif
        chk("t6_count_pre", bus.sb_count, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", bus.sb_count, 0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rst_mem_write", bus.mem_write, 0);
        exp_wr.delete();
        exp_rsp.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_post_count", bus.sb_count, 0);
        chk("t6_post_mem_write", bus.mem_write, 0);

        chk("rsp_queue_empty", exp_rsp.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
